// File: rtl/adc_share_ctrl_pkg.sv
// Shared constants for the tag ADC sharing controller.
//   - controller state encodings
//   - requester IDs
//   - default frame geometry and serial clock divider
//   - round-robin pick helper
package loctag_adc_pkg;

  localparam int unsigned CLK_DIV_DEF      = 2;
  localparam int unsigned FRAME_BITS_DEF   = 16;
  localparam int unsigned DATA_LSB_DEF     = 5;
  localparam int unsigned DATA_BITS_DEF    = 8;
  localparam int unsigned QUIET_CYCLES_DEF = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_QUIET = 2'd3;

  localparam logic REQ_RSS = 1'b0;
  localparam logic REQ_ENV = 1'b1;

  // Winner for a non-empty request vector; on a tie the one not served last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic rr_last);
    return (req == 2'b11) ? ~rr_last : req[REQ_ENV];
  endfunction

endpackage

// File: rtl/adc_share_ctrl_if.sv
// Requester handshake plus ADC pin bundle for adc_share_ctrl.
//   slave  : the controller side (drives grant/result and ADC cs/clk)
//   master : tag FSM / ADC side (drives req, hold, adc_so)
interface adc_share_ctrl_if
  import loctag_adc_pkg::*;
#(
  parameter int unsigned DATA_BITS = DATA_BITS_DEF
);
  logic [1:0]           req;
  logic                 hold;
  logic                 grant_id;
  logic                 busy;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 adc_cs;
  logic                 adc_clk;
  logic                 adc_so;

  modport slave (
    input  req, hold, adc_so,
    output grant_id, busy, data, valid, adc_cs, adc_clk
  );

  modport master (
    output req, hold, adc_so,
    input  grant_id, busy, data, valid, adc_cs, adc_clk
  );
endinterface

// File: rtl/adc_share_ctrl_frame_engine.sv
// One serial ADC conversion frame: chip select, divided serial clock, MSB-first capture.
//   clk, reset  : system clock, async active-high reset
//   start_i     : begin a frame (cs drops next cycle)
//   adc_so_i    : ADC serial data, sampled on the cycle adc_clk rises
//   adc_cs_o    : chip select, active low
//   adc_clk_o   : serial clock, idle high
//   data_o      : result field of the captured frame
//   done_o      : one-cycle pulse after the last rising edge
module adc_frame_engine
  import loctag_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned FRAME_BITS = FRAME_BITS_DEF,
  parameter int unsigned DATA_LSB   = DATA_LSB_DEF,
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic                 adc_so_i,
  output logic                 adc_cs_o,
  output logic                 adc_clk_o,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 done_o
);
  localparam int unsigned DIV_W = 4;
  localparam int unsigned EDGES = 2 * FRAME_BITS;
  localparam int unsigned EW    = $clog2(EDGES + 1);
  // Only bits that can still reach the result field are kept; older bits fall off the top.
  localparam int unsigned SW    = DATA_LSB + DATA_BITS;

  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [EW-1:0]    edge_q, edge_d;
  logic [SW-1:0]    shift_q, shift_d;
  logic             done_q, done_d;

  // Half-period timing, clock toggling and capture.
  always_comb begin
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    div_d   = div_q;
    edge_d  = edge_q;
    shift_d = shift_q;
    done_d  = 1'b0;
    if (start_i) begin
      cs_d   = 1'b0;
      sclk_d = 1'b1;
      div_d  = '0;
      edge_d = '0;
    end else if (!cs_q) begin
      if (div_q == DIV_W'(CLK_DIV - 1)) begin
        div_d  = '0;
        sclk_d = ~sclk_q;
        edge_d = edge_q + EW'(1);
        if (!sclk_q) begin
          shift_d = {shift_q[SW-2:0], adc_so_i};
        end
        if (edge_q == EW'(EDGES - 1)) begin
          cs_d   = 1'b1;
          done_d = 1'b1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      div_q   <= '0;
      edge_q  <= '0;
      shift_q <= '0;
      done_q  <= 1'b0;
    end else begin
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      shift_q <= shift_d;
      done_q  <= done_d;
    end
  end

  assign adc_cs_o  = cs_q;
  assign adc_clk_o = sclk_q;
  assign data_o    = shift_q[SW-1 -: DATA_BITS];
  assign done_o    = done_q;

endmodule

// File: rtl/adc_share_ctrl.sv
// Round-robin sharing of the tag's serial ADC between the RSS sampler (0) and
// the envelope detector (1); one full frame per grant, result tagged by requester.
//   clk, reset : system clock, async active-high reset
//   bus        : req/hold in, grant_id/busy/data/valid out, adc_cs/adc_clk out, adc_so in
module adc_share_ctrl
  import loctag_adc_pkg::*;
#(
  parameter int unsigned CLK_DIV      = CLK_DIV_DEF,
  parameter int unsigned FRAME_BITS   = FRAME_BITS_DEF,
  parameter int unsigned DATA_LSB     = DATA_LSB_DEF,
  parameter int unsigned DATA_BITS    = DATA_BITS_DEF,
  parameter int unsigned QUIET_CYCLES = QUIET_CYCLES_DEF
) (
  input logic             clk,
  input logic             reset,
  adc_share_ctrl_if.slave bus
);
  localparam int unsigned QW = 4;

  logic [1:0]           state_q, state_d;
  logic                 rr_last_q, rr_last_d;
  logic                 gid_q, gid_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic [QW-1:0]        qcnt_q, qcnt_d;
  logic                 start_c;
  logic                 win_c;
  logic                 eng_done;
  logic [DATA_BITS-1:0] eng_data;

  adc_frame_engine #(
    .CLK_DIV   (CLK_DIV),
    .FRAME_BITS(FRAME_BITS),
    .DATA_LSB  (DATA_LSB),
    .DATA_BITS (DATA_BITS)
  ) u_engine (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start_c),
    .adc_so_i (bus.adc_so),
    .adc_cs_o (bus.adc_cs),
    .adc_clk_o(bus.adc_clk),
    .data_o   (eng_data),
    .done_o   (eng_done)
  );

  // Arbitration, result capture and inter-frame quiet time.
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    gid_d     = gid_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    data_d    = data_q;
    qcnt_d    = qcnt_q;
    start_c   = 1'b0;
    win_c     = rr_pick(bus.req, rr_last_q);
    case (state_q)
      ST_IDLE: begin
        if (!bus.hold && (bus.req != 2'b00)) begin
          start_c   = 1'b1;
          gid_d     = win_c;
          rr_last_d = win_c;
          busy_d    = 1'b1;
          state_d   = ST_CONV;
        end
      end
      ST_CONV: begin
        if (eng_done) begin
          valid_d = 1'b1;
          data_d  = eng_data;
          qcnt_d  = QW'(1);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        // The DONE cycle itself is the first quiet cycle.
        if (QUIET_CYCLES <= 1) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_QUIET;
        end
      end
      default: begin
        if (qcnt_q >= QW'(QUIET_CYCLES - 1)) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rr_last_q <= 1'b1;
      gid_q     <= 1'b0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      qcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      gid_q     <= gid_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      qcnt_q    <= qcnt_d;
    end
  end

  assign bus.grant_id = gid_q;
  assign bus.busy     = busy_q;
  assign bus.valid    = valid_q;
  assign bus.data     = data_q;

endmodule

// File: tb/tb_adc_share_ctrl.sv
// Self-checking bench for adc_share_ctrl: timeline model of each granted frame,
// serial ADC model, and directed scenarios with hand-computed expectations.
module tb_adc_share_ctrl;
  import loctag_adc_pkg::*;

  localparam int FB       = 16;
  localparam int DIV      = 2;
  localparam int CS_LAST  = 2 * FB * DIV;   // last cycle offset with cs low (64)
  localparam int VAL_OFF  = CS_LAST + 2;    // valid offset (66)
  localparam int FREE_OFF = VAL_OFF + 3;    // first offset the controller is idle again (69)
  localparam int NONE     = 1000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [15:0] frame = 16'h0000;

  adc_share_ctrl_if #(.DATA_BITS(8)) bus ();

  adc_share_ctrl dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Serial ADC: presents frame MSB first, advancing after each rising adc_clk.
  int bit_n = 0;
  int rises = 0;
  always @(negedge bus.adc_cs) begin
    bit_n = 0;
    rises = 0;
    bus.adc_so = frame[15];
  end
  always @(posedge bus.adc_clk) begin
    rises++;
    bit_n++;
    if (bit_n < FB) bus.adc_so = frame[15 - bit_n];
  end

  // Frame timeline model: offset of the current cycle relative to the last grant.
  int         off_next = NONE;
  logic       m_rr = 1'b1;
  logic       m_gid = 1'b0;
  logic [7:0] m_data = 8'h00;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      off_next = NONE;
      m_rr     = 1'b1;
      m_gid    = 1'b0;
      m_data   = 8'h00;
    end else begin
      if (off_next >= FREE_OFF && !bus.hold && bus.req != 2'b00) begin
        if (bus.req == 2'b11) m_gid = (m_rr == 1'b0);
        else                  m_gid = (bus.req == 2'b10);
        m_rr     = m_gid;
        off_next = 1;
      end else if (off_next < NONE) begin
        off_next++;
      end
      if (off_next == VAL_OFF) m_data = 8'((frame / 32) % 256);
    end
  end

  // Per-cycle comparison against the model.
  logic prev_cs = 1'b1;
  int   hi_run = 100;
  always @(negedge clk) begin
    int   o;
    logic e_cs, e_clk, e_busy, e_valid;
    if (reset) begin
      chk("rst_cs", 32'(bus.adc_cs), 32'(1));
      chk("rst_sclk", 32'(bus.adc_clk), 32'(1));
      chk("rst_busy", 32'(bus.busy), 32'(0));
      chk("rst_valid", 32'(bus.valid), 32'(0));
      chk("rst_gid", 32'(bus.grant_id), 32'(0));
      chk("rst_data", 32'(bus.data), 32'(0));
      prev_cs = 1'b1;
      hi_run  = 100;
    end else begin
      o       = off_next;
      e_cs    = !(o >= 1 && o <= CS_LAST);
      e_clk   = e_cs ? 1'b1 : ((((o - 1) / DIV) % 2) == 0);
      e_busy  = (o >= 1 && o < FREE_OFF);
      e_valid = (o == VAL_OFF);
      chk("adc_cs", 32'(bus.adc_cs), 32'(e_cs));
      chk("adc_clk", 32'(bus.adc_clk), 32'(e_clk));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("valid", 32'(bus.valid), 32'(e_valid));
      chk("grant_id", 32'(bus.grant_id), 32'(m_gid));
      chk("data", 32'(bus.data), 32'(m_data));
      if (prev_cs && !bus.adc_cs) chk("cs_gap_ge3", 32'(hi_run >= 3), 32'(1));
      if (!prev_cs && bus.adc_cs) chk("sclk_rises", 32'(rises), 32'(FB));
      hi_run  = bus.adc_cs ? hi_run + 1 : 0;
      prev_cs = bus.adc_cs;
    end
  end

  task automatic wait_valid(input int lim, output int vc);
    vc = -1;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        vc = cyc;
        break;
      end
    end
    if (vc < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout at cycle %0d: got no valid within %0d cycles", cyc, lim);
    end
  endtask

  logic exp_ids [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    int c0, vc, nv, ncs;
    logic ids [4];
    bus.req    = 2'b00;
    bus.hold   = 1'b0;
    bus.adc_so = 1'b0;
    frame      = 16'h1FE0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Single request from requester 0.
    @(posedge clk); #1;
    bus.req = 2'b01;
    c0 = cyc;
    @(posedge clk); #1;
    chk("t1_cs_low_cycle1", 32'(bus.adc_cs), 32'(0));
    wait_valid(200, vc);
    chk("t1_latency", 32'(vc - c0), 32'(66));
    chk("t1_gid", 32'(bus.grant_id), 32'(0));
    chk("t1_data", 32'(bus.data), 32'(8'hFF));
    @(posedge clk); #1;
    bus.req = 2'b00;
    repeat (5) @(posedge clk);

    // Contention from reset: grants alternate starting with requester 0.
    #1;
    reset   = 1'b1;
    frame   = 16'h14A0;
    bus.req = 2'b11;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid(200, vc);
      ids[k] = bus.grant_id;
      chk("t2_data", 32'(bus.data), 32'(8'hA5));
    end
    @(posedge clk); #1;
    bus.req = 2'b00;
    for (int k = 0; k < 4; k++) chk("t2_rr_order", 32'(ids[k]), 32'(exp_ids[k]));
    repeat (5) @(posedge clk);

    // Hold blocks grants, release grants next cycle, mid-frame hold is ignored.
    frame = 16'h001F;
    #1;
    bus.hold = 1'b1;
    bus.req  = 2'b10;
    repeat (10) begin
      @(negedge clk);
      chk("t3_hold_cs", 32'(bus.adc_cs), 32'(1));
      chk("t3_hold_busy", 32'(bus.busy), 32'(0));
    end
    @(posedge clk); #1;
    bus.hold = 1'b0;
    @(posedge clk); #1;
    chk("t3_cs_after_release", 32'(bus.adc_cs), 32'(0));
    repeat (20) @(posedge clk);
    #1;
    bus.hold = 1'b1;
    wait_valid(100, vc);
    chk("t3_gid", 32'(bus.grant_id), 32'(1));
    chk("t3_data_outside_field", 32'(bus.data), 32'(8'h00));
    @(posedge clk); #1;
    bus.req  = 2'b00;
    bus.hold = 1'b0;
    repeat (5) @(posedge clk);

    // Early release at cycle 10 of the frame: one frame, then idle.
    frame = 16'h1FE0;
    #1;
    bus.req = 2'b01;
    c0 = cyc;
    repeat (10) @(posedge clk);
    #1;
    bus.req = 2'b00;
    wait_valid(100, vc);
    chk("t4_latency", 32'(vc - c0), 32'(66));
    chk("t4_data", 32'(bus.data), 32'(8'hFF));
    nv  = 0;
    ncs = 0;
    repeat (100) begin
      @(negedge clk);
      nv  += int'(bus.valid);
      ncs += int'(!bus.adc_cs);
    end
    chk("t4_no_second_valid", 32'(nv), 32'(0));
    chk("t4_no_second_frame", 32'(ncs), 32'(0));
    chk("t4_idle_busy", 32'(bus.busy), 32'(0));

    // Reset at cycle 30 of a frame, then a fresh full frame.
    frame = 16'h14A0;
    @(posedge clk); #1;
    bus.req = 2'b01;
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("t5_rst_cs", 32'(bus.adc_cs), 32'(1));
    chk("t5_rst_sclk", 32'(bus.adc_clk), 32'(1));
    chk("t5_rst_busy", 32'(bus.busy), 32'(0));
    chk("t5_rst_valid", 32'(bus.valid), 32'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    c0 = cyc;
    wait_valid(200, vc);
    chk("t5_latency", 32'(vc - c0), 32'(66));
    chk("t5_data", 32'(bus.data), 32'(8'hA5));
    chk("t5_gid", 32'(bus.grant_id), 32'(0));
    @(posedge clk); #1;
    bus.req = 2'b00;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
